// File: rtl/dco_nco_pkg.sv
// Shared constants and types for the DCO/NCO phase-noise model.
// The optional phase-noise feature is enabled by defining DCO_NCO_PN_PN_EN.
package dco_nco_pkg;

  localparam int FCW_W_DEF   = 18;
  localparam int PHASE_W_DEF = 20;

  typedef logic [FCW_W_DEF-1:0]   fcw_t;
  typedef logic [PHASE_W_DEF-1:0] phase_t;

  localparam fcw_t FCW_BASE = 18'h08000;
  localparam int   KV       = 4;
  localparam int   KD       = 64;
  localparam int   KT       = 64;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting towards the MSB
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic signed [7:0] WANDER_MAX = 8'sd64;
  localparam logic signed [7:0] WANDER_MIN = -8'sd64;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dco_nco_chan.sv
// One oscillator channel: phase accumulator plus optional LFSR jitter/wander noise.
// Noise logic exists only when DCO_NCO_PN_PN_EN is defined.
module dco_nco_chan
  import dco_nco_pkg::*;
#(
  parameter int PHASE_W = 20,
  parameter int FCW_W   = 18,
  parameter int CH_IDX  = 0,
  parameter int DECIM   = 250
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [FCW_W-1:0] fcw_i,
  output logic             vout_o
);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;
  logic [PHASE_W-1:0] noise;

`ifdef DCO_NCO_PN_PN_EN
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [15:0]       lfsr_q;
  logic signed [7:0] wander_q;
  logic [DEC_W-1:0]  dec_q;
  logic signed [7:0] jitter;
  logic signed [7:0] noise_s;

  // Jitter spans -8..7 and wander -64..64, so the sum always fits 8 signed bits.
  assign jitter  = $signed({4'b0000, lfsr_q[3:0]}) - 8'sd8;
  assign noise_s = jitter + wander_q;
  assign noise   = {{(PHASE_W-8){noise_s[7]}}, noise_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q   <= LFSR_SEED ^ 16'(CH_IDX);
      wander_q <= '0;
      dec_q    <= '0;
    end else if (en_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
      if (dec_q == DEC_W'(DECIM - 1)) begin
        dec_q <= '0;
        if (lfsr_q[15]) begin
          if (wander_q != WANDER_MAX) wander_q <= wander_q + 8'sd1;
        end else begin
          if (wander_q != WANDER_MIN) wander_q <= wander_q - 8'sd1;
        end
      end else begin
        dec_q <= dec_q + 1'b1;
      end
    end
  end
`else
  assign noise = '0;
`endif

  assign phase_d = phase_q + PHASE_W'(fcw_i) + noise;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    phase_q <= '0;
    else if (en_i) phase_q <= phase_d;
  end

  assign vout_o = phase_q[PHASE_W-1];

endmodule

// File: rtl/dco_nco_pn.sv
// Multi-channel DCO/NCO with windowed FCW averaging; input registers, fcw_r and the
// shared window counter live here. Define DCO_NCO_PN_PN_EN to add per-channel phase noise.
module dco_nco_pn #(
  parameter int                NCH      = 2,
  parameter int                PHASE_W  = 20,
  parameter int                FCW_W    = 18,
  parameter int                DCTRL_W  = 9,
  parameter logic [FCW_W-1:0]  FCW_BASE = FCW_W'(dco_nco_pkg::FCW_BASE),
  parameter int                KV       = dco_nco_pkg::KV,
  parameter int                KD       = dco_nco_pkg::KD,
  parameter int                KT       = dco_nco_pkg::KT,
  parameter int                OSR_LOG2 = 4,
  parameter int                DECIM    = 250
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NCH*8-1:0]       vctrl_code,
  input  logic [NCH*DCTRL_W-1:0] dctrl,
  input  logic [NCH*4-1:0]       dctrltc,
  input  logic [NCH-1:0]         dctrltc_dsm,
  output logic [NCH-1:0]         vout,
  output logic [NCH*FCW_W-1:0]   fcw_avg,
  output logic                   avg_valid
);

  localparam int SUM_W = FCW_W + 32;
  localparam int ACC_W = FCW_W + OSR_LOG2;
  localparam logic [SUM_W-1:0] FCW_MAX = SUM_W'({FCW_W{1'b1}});

  logic [NCH*8-1:0]       vctrl_q;
  logic [NCH*DCTRL_W-1:0] dctrl_q;
  logic [NCH*4-1:0]       tc_q;
  logic [NCH-1:0]         dsm_q;

  logic [FCW_W-1:0] fcw_q   [NCH];
  logic [FCW_W-1:0] fcw_d   [NCH];
  logic [ACC_W-1:0] acc_q   [NCH];
  logic [ACC_W-1:0] acc_sum [NCH];
  logic [FCW_W-1:0] avg_q   [NCH];

  logic [OSR_LOG2-1:0] cnt_q;
  logic                avg_valid_q;
  logic                wrap;

  // NOTE: every output of this block gets a value on every path, so no latch is inferred.
  always_comb begin : fcw_calc
    logic [SUM_W-1:0] sum;
    sum = '0;
    for (int c = 0; c < NCH; c++) begin
      sum = SUM_W'(FCW_BASE)
          + SUM_W'(vctrl_q[c*8 +: 8]) * SUM_W'(KV)
          + SUM_W'(dctrl_q[c*DCTRL_W +: DCTRL_W]) * SUM_W'(KD)
          + (SUM_W'(tc_q[c*4 +: 4]) + SUM_W'(dsm_q[c])) * SUM_W'(KT);
      fcw_d[c]   = (sum > FCW_MAX) ? {FCW_W{1'b1}} : sum[FCW_W-1:0];
      acc_sum[c] = acc_q[c] + ACC_W'(fcw_q[c]);
    end
  end

  // The window closes on its last enabled clock; en dropping afterwards cannot cancel it.
  assign wrap = en && (cnt_q == {OSR_LOG2{1'b1}});

  // NOTE: the small per-channel register arrays are reset so a partial window never leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vctrl_q     <= '0;
      dctrl_q     <= '0;
      tc_q        <= '0;
      dsm_q       <= '0;
      cnt_q       <= '0;
      avg_valid_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        fcw_q[c] <= '0;
        acc_q[c] <= '0;
        avg_q[c] <= '0;
      end
    end else begin
      vctrl_q     <= vctrl_code;
      dctrl_q     <= dctrl;
      tc_q        <= dctrltc;
      dsm_q       <= dctrltc_dsm;
      avg_valid_q <= wrap;
      for (int c = 0; c < NCH; c++) fcw_q[c] <= fcw_d[c];
      if (en) begin
        cnt_q <= cnt_q + 1'b1;
        for (int c = 0; c < NCH; c++) begin
          if (wrap) begin
            avg_q[c] <= FCW_W'(acc_sum[c] >> OSR_LOG2);
            acc_q[c] <= '0;
          end else begin
            acc_q[c] <= acc_sum[c];
          end
        end
      end
    end
  end

  assign avg_valid = avg_valid_q;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    dco_nco_chan #(
      .PHASE_W (PHASE_W),
      .FCW_W   (FCW_W),
      .CH_IDX  (c),
      .DECIM   (DECIM)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en),
      .fcw_i  (fcw_q[c]),
      .vout_o (vout[c])
    );
    assign fcw_avg[c*FCW_W +: FCW_W] = avg_q[c];
  end

endmodule

// File: tb/tb_dco_nco_pn.sv
// Randomised and directed checks of dco_nco_pn against a cycle-level arithmetic model.
// Build with DCO_NCO_PN_PN_EN defined to exercise the phase-noise checks.
module tb_dco_nco_pn;

  localparam int  NCH     = 2;
  localparam int  FW      = 18;
  localparam int  KD_SAT  = 1024;
  localparam longint FMAX = (64'd1 << FW) - 1;
  localparam longint PMASK = (64'd1 << 20) - 1;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [NCH*8-1:0]  vctrl_code;
  logic [NCH*9-1:0]  dctrl;
  logic [NCH*4-1:0]  dctrltc;
  logic [NCH-1:0]    dctrltc_dsm;

  logic [NCH-1:0]    vout_a      [2];
  logic [NCH*FW-1:0] fcw_avg_a   [2];
  logic              avg_valid_a [2];

  dco_nco_pn dut (
    .clk(clk), .rst_n(rst_n), .en(en), .vctrl_code(vctrl_code), .dctrl(dctrl),
    .dctrltc(dctrltc), .dctrltc_dsm(dctrltc_dsm),
    .vout(vout_a[0]), .fcw_avg(fcw_avg_a[0]), .avg_valid(avg_valid_a[0])
  );

  dco_nco_pn #(.KD(KD_SAT)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .vctrl_code(vctrl_code), .dctrl(dctrl),
    .dctrltc(dctrltc), .dctrltc_dsm(dctrltc_dsm),
    .vout(vout_a[1]), .fcw_avg(fcw_avg_a[1]), .avg_valid(avg_valid_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: increments applied two edges after the inputs, 16-sample means.
  longint m_phase [2][NCH];
  longint m_acc   [2][NCH];
  longint m_avg   [2][NCH];
  longint m_pipe  [2][NCH][$];
  int     m_cnt;
  bit     m_valid;

  function automatic longint exp_fcw(input int kd, input int c);
    longint s;
    s = 64'h8000 + longint'(vctrl_code[c*8 +: 8]) * 4 + longint'(dctrl[c*9 +: 9]) * kd
      + (longint'(dctrltc[c*4 +: 4]) + longint'(dctrltc_dsm[c])) * 64;
    return (s > FMAX) ? FMAX : s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < NCH; c++) begin
        m_phase[i][c] = 0;
        m_acc[i][c]   = 0;
        m_avg[i][c]   = 0;
        m_pipe[i][c]  = {};
        m_pipe[i][c].push_back(0);
        m_pipe[i][c].push_back(64'h8000);
      end
    m_cnt   = 0;
    m_valid = 0;
  endtask

  task automatic compare_outputs();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("avg_valid[%0d]", i), 64'(avg_valid_a[i]), 64'(m_valid));
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("fcw_avg[%0d][%0d]", i, c), 64'(fcw_avg_a[i][c*FW +: FW]), m_avg[i][c]);
`ifndef DCO_NCO_PN_PN_EN
        check($sformatf("vout[%0d][%0d]", i, c), 64'(vout_a[i][c]), (m_phase[i][c] >> 19) & 1);
`endif
      end
    end
  endtask

  task automatic tick(input bit drop_en = 1'b0);
    longint used;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      m_valid = 0;
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < NCH; c++) begin
          used = m_pipe[i][c].pop_front();
          m_pipe[i][c].push_back(exp_fcw(i == 0 ? 64 : KD_SAT, c));
          if (en) begin
            m_phase[i][c] = (m_phase[i][c] + used) & PMASK;
            m_acc[i][c]   = m_acc[i][c] + used;
          end
        end
      if (en) begin
        m_cnt++;
        if (m_cnt == 16) begin
          for (int i = 0; i < 2; i++)
            for (int c = 0; c < NCH; c++) begin
              m_avg[i][c] = m_acc[i][c] / 16;
              m_acc[i][c] = 0;
            end
          m_cnt   = 0;
          m_valid = 1;
        end
      end
    end
    if (drop_en) begin
      #1;
      en = 1'b0;
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!avg_valid_a[0] && n < 200);
    check("strobe_seen", 64'(avg_valid_a[0]), 64'd1);
  endtask

  task automatic assert_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_vout", 64'({vout_a[1], vout_a[0]}), 64'd0);
    check("async_rst_valid", 64'({avg_valid_a[1], avg_valid_a[0]}), 64'd0);
    check("async_rst_avg0", 64'(fcw_avg_a[0]), 64'd0);
    check("async_rst_avg1", 64'(fcw_avg_a[1]), 64'd0);
  endtask

  task automatic set_inputs(input bit zero, input bit max);
    if (zero) begin
      vctrl_code = '0; dctrl = '0; dctrltc = '0; dctrltc_dsm = '0;
    end else if (max) begin
      vctrl_code = '1; dctrl = '1; dctrltc = '1; dctrltc_dsm = '1;
    end else begin
      vctrl_code  = NCH*8'($urandom);
      dctrl       = NCH*9'({$urandom, $urandom});
      dctrltc     = NCH*4'($urandom);
      dctrltc_dsm = NCH'($urandom);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    rst_n = 1'b0;
    en    = 1'b0;
    set_inputs(1'b1, 1'b0);
    model_reset();

    // Reset state
    repeat (3) tick();
    check("rst_avg_valid", 64'(avg_valid_a[0]), 64'd0);
    check("rst_fcw_avg", 64'(fcw_avg_a[0]), 64'd0);
    check("rst_vout", 64'(vout_a[0]), 64'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Zero inputs: mean equals base FCW, vout toggles every 16 clocks
    en = 1'b1;
    begin
      int  last_rise = -1;
      int  hi_run    = 0;
      int  n_rise    = 0;
      bit  prev      = vout_a[0][0];
      for (int k = 0; k < 110; k++) begin
        tick();
        if (avg_valid_a[0]) begin
          check("zero_avg_ch0", 64'(fcw_avg_a[0][0 +: FW]), 64'h8000);
          check("zero_avg_ch1", 64'(fcw_avg_a[0][FW +: FW]), 64'h8000);
        end
`ifndef DCO_NCO_PN_PN_EN
        if (vout_a[0][0] && !prev) begin
          if (last_rise >= 0) check("vout_period", 64'(k - last_rise), 64'd32);
          last_rise = k;
          n_rise++;
        end
        if (!vout_a[0][0] && prev && last_rise >= 0) check("vout_high", 64'(hi_run), 64'd16);
        hi_run = vout_a[0][0] ? hi_run + 1 : 0;
        prev   = vout_a[0][0];
`endif
      end
`ifndef DCO_NCO_PN_PN_EN
      check("vout_rises", 64'(n_rise >= 3), 64'd1);
`endif
    end

    // Strobe spacing, and a 5-clock pause delays the next strobe by 5
    wait_strobe(n);
    wait_strobe(n);
    check("strobe_gap", 64'(n), 64'd16);
    repeat (5) tick();
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    wait_strobe(n);
    check("strobe_gap_pause", 64'(n + 10), 64'd21);

    // Saturation with every control at full scale
    set_inputs(1'b0, 1'b1);
    repeat (3) wait_strobe(n);
    check("sat_avg_ch0", 64'(fcw_avg_a[1][0 +: FW]), 64'h3FFFF);
    check("sat_avg_ch1", 64'(fcw_avg_a[1][FW +: FW]), 64'h3FFFF);
    check("nosat_avg_ch0", 64'(fcw_avg_a[0][0 +: FW]), 64'h107BC);

    // Reset at window count 7 discards the window
    set_inputs(1'b0, 1'b0);
    wait_strobe(n);
    repeat (7) tick();
    assert_reset();
    pulses = 0;
    repeat (3) begin
      tick();
      pulses += avg_valid_a[0];
    end
    check("rst_mid_no_strobe", 64'(pulses), 64'd0);
    rst_n = 1'b1;
    wait_strobe(n);
    check("rst_first_strobe", 64'(n), 64'd16);

    // en dropping right after the wrap clock still yields exactly one strobe
    repeat (15) tick();
    tick(1'b1);
    pulses = avg_valid_a[0];
    repeat (6) begin
      tick();
      pulses += avg_valid_a[0];
    end
    check("wrap_drop_pulses", 64'(pulses), 64'd1);
    en = 1'b1;

    // Randomised traffic
    for (int k = 0; k < 300; k++) begin
      int r = int'($urandom_range(0, 9));
      set_inputs(r == 0, r == 1);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 40) == 0) begin
        assert_reset();
        tick();
        rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 8)) tick();
    end

`ifdef DCO_NCO_PN_PN_EN
    // Phase noise: mean unaffected, wander bounded, channels diverge
    begin
      int w0, w1, diff;
      diff = 0;
      set_inputs(1'b0, 1'b0);
      en = 1'b1;
      for (int k = 0; k < 1500; k++) begin
        tick();
        w0 = int'(dut.g_chan[0].u_chan.wander_q);
        w1 = int'(dut.g_chan[1].u_chan.wander_q);
        if (k % 25 == 0) begin
          check("wander0_bound", 64'(w0 <= 64 && w0 >= -64), 64'd1);
          check("wander1_bound", 64'(w1 <= 64 && w1 >= -64), 64'd1);
        end
        if (k > 40 && avg_valid_a[0])
          check("pn_avg_const", 64'(fcw_avg_a[0][0 +: FW]), 64'(exp_fcw(64, 0)));
        if (vout_a[0][0] != vout_a[0][1]) diff++;
      end
      check("pn_chan_differ", 64'(diff > 0), 64'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dco_nco_pn.md
DCO_NCO_PN -- requirements
Module: dco_nco_pn

Interface
REQ-001 SHALL have parameter NCH, default 2: number of independent oscillator channels.
REQ-002 SHALL have parameter PHASE_W, default 20: phase accumulator width.
REQ-003 SHALL have parameter FCW_W, default 18: frequency control word width.
REQ-004 SHALL have parameter DCTRL_W, default 9: coarse-bank code width.
REQ-005 SHALL have parameter FCW_BASE, default 18'h08000: free-running FCW.
REQ-006 SHALL have parameters KV, KD and KT, defaults 4, 64 and 64: FCW LSBs per vctrl, dctrl and tracking-bank LSB.
REQ-007 SHALL have parameter OSR_LOG2, default 4: log2 of the averaging window length.
REQ-008 SHALL have parameter DECIM, default 250: wander update interval in clocks.
REQ-009 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-010 SHALL have port rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-011 SHALL have port en, input, 1 bit: run enable shared by all channels.
REQ-012 SHALL have port vctrl_code, input, NCH*8 bits: unsigned varactor code per channel.
REQ-013 SHALL have port dctrl, input, NCH*DCTRL_W bits: unsigned coarse code per channel.
REQ-014 SHALL have port dctrltc, input, NCH*4 bits: tracking-bank code per channel.
REQ-015 SHALL have port dctrltc_dsm, input, NCH bits: sigma-delta LSB per channel.
REQ-016 SHALL have port vout, output, NCH bits: oscillator output, equal to the phase MSB.
REQ-017 SHALL have port fcw_avg, output, NCH*FCW_W bits: windowed mean FCW per channel.
REQ-018 SHALL have port avg_valid, output, 1 bit: one-cycle strobe marking a new fcw_avg.

Function
REQ-019 SHALL register all control inputs once; fcw_r = FCW_BASE + vctrl*KV + dctrl*KD + (dctrltc+dctrltc_dsm)*KT, computed with full-width intermediates.
REQ-020 SHALL saturate fcw_r to 2^FCW_W-1 on overflow; it never wraps.
REQ-021 SHALL, when en=1, update each channel as phase <= phase + fcw_r + noise (modulo 2^PHASE_W); an input change therefore reaches the phase increment 2 clocks later.
REQ-022 SHALL hold phase, vout and the averaging state when en=0; re-enable resumes from the held values.
REQ-023 SHALL, per channel, accumulate fcw_r (not noise) over 2^OSR_LOG2 enabled cycles; on the final cycle of the window fcw_avg <= (acc+fcw_r)>>OSR_LOG2, avg_valid=1 for that single cycle, acc <= 0 and the window counter wraps to 0.
REQ-024 SHALL use one window counter shared by all channels, so avg_valid is common to every channel.
REQ-025 SHALL treat en falling on the wrap cycle as completing the window: the strobe still fires.
REQ-026 SHALL keep fcw_avg stable between strobes.

Reset
REQ-027 SHALL, while rst_n=0, hold phase, fcw_r, acc, the window counter, fcw_avg and the wander state at 0, with vout=0 and avg_valid=0.
REQ-028 SHALL release reset synchronously: first phase update on the first enabled edge after rst_n rises.
REQ-029 SHALL, on reset asserted mid-window, discard the partial window with no strobe; the LFSRs reload their seeds.

Configuration
REQ-030 SHALL, with DCO_NCO_PN_PN_EN defined, give each channel a 16-bit maximal LFSR (seed 16'hACE1 XOR channel index) advanced every enabled clock.
REQ-031 SHALL, with PN_EN defined, apply as noise a signed jitter term (LFSR[3:0]-8) plus a wander register.
REQ-032 SHALL, with PN_EN defined, update the wander register every DECIM enabled clocks by +1/-1 per LFSR[15], clamped to ±64.
REQ-033 SHALL, without DCO_NCO_PN_PN_EN, make noise identically 0 and synthesise no LFSR or wander logic.

Structure
REQ-034 SHALL place FCW_BASE, KV, KD, KT and the LFSR seed and taps in package dco_nco_pkg, together with typedefs fcw_t and phase_t.
REQ-035 SHALL implement one channel (phase accumulator and noise) in sub-module dco_nco_chan, instantiated NCH times with a generate loop.
REQ-036 SHALL keep the shared window counter and the input registers in the top level.

Verification
REQ-037 SHALL check: PN off, all inputs 0, en=1 -> fcw_avg=0x08000 at every strobe, and vout period exactly 32 clocks (16 high, 16 low).
REQ-038 SHALL check: vctrl=255, dctrl=511, dctrltc=15, dsm=1 -> fcw_r saturates to 0x3FFFF, no wrap.
REQ-039 SHALL check: strobes arrive every 16 enabled clocks; with en low for 5 clocks mid-window, the next strobe is 5 clocks late.
REQ-040 SHALL check: rst_n low at window count 7 -> no strobe, all outputs 0; after release the first strobe comes 16 enabled clocks later.
REQ-041 SHALL check: PN on, constant inputs -> fcw_avg unchanged, |wander| never exceeds 64, and the two channels produce different vout edge times.
REQ-042 SHALL check: en falling on the wrap cycle -> avg_valid still pulses once.
